// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, response constants and slave FSM states.
// Latency: none (declarations only). Backpressure: n/a.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_state_t;

    // Only aligned word accesses that land inside the array are served.
    function automatic logic ahb_is_legal(input logic [31:0] addr, input logic [2:0] size,
                                          input int unsigned depth);
        return (size == HSIZE_WORD) && (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/ahb_slv_regfile.sv
// DEPTH x 32 storage: synchronous write, combinational read, async clear.
// Latency: write visible the cycle after i_we; read is same-cycle. Backpressure: none.
module ahb_slv_regfile #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdat,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdat
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word SRAM slave; data-phase wait states only when AHB_SLV_WAIT_EN is defined.
// Latency: WAIT_CYCLES wait states per transfer with the macro, zero without; errors take two cycles.
// Backpressure: hreadyout low in wait states and ERR1; address phases taken only with hready high.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int IDX_W = $clog2(DEPTH);

    if (DEPTH < 4 || DEPTH > 64 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_param
        $error("ahb_slave_mem: DEPTH or WAIT_CYCLES out of range");
    end

    ahb_state_t       r_state;
    logic             r_hreadyout;
    logic             r_hresp;
    logic [IDX_W-1:0] r_idx;
    logic             r_write;

    logic             w_accept;
    logic             w_legal;
    logic             w_done;
    logic             w_entry_rdy;
    ahb_state_t       w_nxt_state;
    logic             w_nxt_rdy;
    logic             w_nxt_resp;
    logic [31:0]      w_rd_dat;

    assign w_accept = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign w_legal  = ahb_is_legal(haddr, hsize, DEPTH);
    assign w_done   = (r_state == ST_DATA) && r_hreadyout;

`ifdef AHB_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    logic [3:0] r_cnt;
    assign w_entry_rdy = (WAIT_LD == 4'd0);
`else
    assign w_entry_rdy = 1'b1;
`endif

    // Next state whenever the slave is free to take an address phase (IDLE, ERR2, DATA done).
    always_comb begin
        w_nxt_state = ST_IDLE;
        w_nxt_rdy   = 1'b1;
        w_nxt_resp  = HRESP_OKAY;
        if (w_accept) begin
            if (w_legal) begin
                w_nxt_state = ST_DATA;
                w_nxt_rdy   = w_entry_rdy;
            end else begin
                w_nxt_state = ST_ERR1;
                w_nxt_rdy   = 1'b0;
                w_nxt_resp  = HRESP_ERROR;
            end
        end
    end

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_idx       <= '0;
            r_write     <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
            r_cnt       <= 4'd0;
`endif
        end else if (r_state == ST_ERR1) begin
            r_state     <= ST_ERR2;
            r_hreadyout <= 1'b1;
        end else if (r_state == ST_DATA && !r_hreadyout) begin
`ifdef AHB_SLV_WAIT_EN
            r_cnt       <= r_cnt - 4'd1;
            r_hreadyout <= (r_cnt == 4'd1);
`else
            r_hreadyout <= 1'b1;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_hreadyout <= w_nxt_rdy;
            r_hresp     <= w_nxt_resp;
            if (w_accept) begin
                r_idx   <= haddr[IDX_W+1:2];
                r_write <= hwrite;
            end
`ifdef AHB_SLV_WAIT_EN
            r_cnt       <= (w_accept && w_legal) ? WAIT_LD : 4'd0;
`endif
        end
    end

    ahb_slv_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .i_clk   (clk),
        .i_rst_n (hresetn),
        .i_we    (w_done && r_write),
        .i_waddr (r_idx),
        .i_wdat  (hwdata),
        .i_raddr (r_idx),
        .o_rdat  (w_rd_dat)
    );

    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;
    assign hrdata    = (w_done && !r_write) ? w_rd_dat : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem (DEPTH=16, WAIT_CYCLES=2); wait-state expectations follow AHB_SLV_WAIT_EN.
module tb_ahb_slave_mem;

`ifdef AHB_SLV_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        clk     = 1'b0;
    logic        hresetn = 1'b1;
    logic        hsel    = 1'b0;
    logic [31:0] haddr   = 32'h0;
    logic [1:0]  htrans  = 2'd0;
    logic        hwrite  = 1'b0;
    logic [2:0]  hsize   = 3'b010;
    logic [31:0] hwdata  = 32'h0;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    assign hready = hreadyout;

    always #5 clk = ~clk;

    ahb_slave_mem #(
        .DEPTH       (16),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .hresetn   (hresetn),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Transfer list for one pipelined burst; p_dat is write data or expected read data.
    logic        p_wr   [8];
    logic [31:0] p_addr [8];
    logic [2:0]  p_size [8];
    logic [31:0] p_dat  [8];
    logic        p_err  [8];
    int          p_n = 0;

    task automatic add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] dat, input logic err);
        p_wr[p_n]   = wr;
        p_addr[p_n] = addr;
        p_size[p_n] = size;
        p_dat[p_n]  = dat;
        p_err[p_n]  = err;
        p_n++;
    endtask

    task automatic drive_addr(input int i);
        hsel   = 1'b1;
        htrans = 2'd2;
        haddr  = p_addr[i];
        hwrite = p_wr[i];
        hsize  = p_size[i];
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = 2'd0;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'b010;
    endtask

    task automatic run_pipe(input string tag);
        int   w;
        logic first_resp;
        drive_addr(0);
        @(posedge clk); #1;
        for (int i = 0; i < p_n; i++) begin
            hwdata = p_wr[i] ? p_dat[i] : 32'h0;
            if (i + 1 < p_n) drive_addr(i + 1);
            else             idle_bus();
            w = 0;
            @(negedge clk);
            first_resp = hresp;
            while (!hreadyout && w < 20) begin
                chk($sformatf("%s[%0d].wait_rdata", tag, i), hrdata, 32'h0);
                w++;
                @(negedge clk);
            end
            chk($sformatf("%s[%0d].waits", tag, i), w, p_err[i] ? 32'd1 : 32'(EXP_WAIT));
            chk($sformatf("%s[%0d].resp1", tag, i), {31'b0, first_resp}, {31'b0, p_err[i]});
            chk($sformatf("%s[%0d].resp", tag, i), {31'b0, hresp}, {31'b0, p_err[i]});
            chk($sformatf("%s[%0d].rdata", tag, i), hrdata,
                (!p_wr[i] && !p_err[i]) ? p_dat[i] : 32'h0);
            @(posedge clk); #1;
        end
        hwdata = 32'h0;
        p_n = 0;
    endtask

    initial begin
        #1 hresetn = 1'b0;
        #1;
        chk("rst.hreadyout", {31'b0, hreadyout}, 32'd1);
        chk("rst.hresp", {31'b0, hresp}, 32'd0);
        chk("rst.hrdata", hrdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) hresetn = 1'b1;
        @(posedge clk); #1;

        add(1'b0, 32'h3C, 3'b010, 32'h0, 1'b0);
        run_pipe("rst_mem");

        add(1'b1, 32'h0, 3'b010, 32'd1, 1'b0);
        add(1'b1, 32'h4, 3'b010, 32'd2, 1'b0);
        add(1'b1, 32'h8, 3'b010, 32'd3, 1'b0);
        add(1'b0, 32'h0, 3'b010, 32'd1, 1'b0);
        add(1'b0, 32'h4, 3'b010, 32'd2, 1'b0);
        add(1'b0, 32'h8, 3'b010, 32'd3, 1'b0);
        run_pipe("b2b");

        add(1'b1, 32'h8, 3'b010, 32'hDEADBEEF, 1'b0);
        add(1'b0, 32'h8, 3'b010, 32'hDEADBEEF, 1'b0);
        run_pipe("wr_rd8");

        add(1'b1, 32'h10, 3'b010, 32'hCAFEF00D, 1'b0);
        add(1'b0, 32'h10, 3'b010, 32'hCAFEF00D, 1'b0);
        add(1'b0, 32'h3C, 3'b010, 32'h0, 1'b0);
        run_pipe("raw");

        add(1'b0, 32'h40, 3'b010, 32'h0, 1'b1);
        add(1'b0, 32'h8, 3'b010, 32'hDEADBEEF, 1'b0);
        run_pipe("oob");

        add(1'b1, 32'h4, 3'b000, 32'h12345678, 1'b1);
        add(1'b0, 32'h4, 3'b010, 32'd2, 1'b0);
        add(1'b1, 32'h6, 3'b010, 32'h87654321, 1'b1);
        add(1'b0, 32'h4, 3'b010, 32'd2, 1'b0);
        run_pipe("badsz");

        hsel = 1'b1; htrans = 2'd1; hwrite = 1'b1; haddr = 32'h4; hsize = 3'b010;
        @(posedge clk); #1;
        hwdata = 32'hBAADF00D;
        idle_bus();
        @(negedge clk);
        chk("busy.hreadyout", {31'b0, hreadyout}, 32'd1);
        chk("busy.hresp", {31'b0, hresp}, 32'd0);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h0;
        @(posedge clk); #1;
        hwdata = 32'hBAADF00D;
        idle_bus();
        @(negedge clk);
        chk("nosel.hreadyout", {31'b0, hreadyout}, 32'd1);
        chk("nosel.hresp", {31'b0, hresp}, 32'd0);
        chk("nosel.hrdata", hrdata, 32'h0);
        @(posedge clk); #1;
        hwdata = 32'h0;
        add(1'b0, 32'h4, 3'b010, 32'd2, 1'b0);
        add(1'b0, 32'h0, 3'b010, 32'd1, 1'b0);
        run_pipe("nofx");

        p_addr[0] = 32'hC; p_wr[0] = 1'b1; p_size[0] = 3'b010;
        drive_addr(0);
        @(posedge clk); #1;
        idle_bus();
        hwdata = 32'h55AA55AA;
        @(negedge clk);
        chk("midrst.pre_rdy", {31'b0, hreadyout}, (EXP_WAIT == 0) ? 32'd1 : 32'd0);
        hresetn = 1'b0;
        #1;
        chk("midrst.hreadyout", {31'b0, hreadyout}, 32'd1);
        chk("midrst.hresp", {31'b0, hresp}, 32'd0);
        chk("midrst.hrdata", hrdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk) hresetn = 1'b1;
        hwdata = 32'h0;
        @(posedge clk); #1;
        add(1'b0, 32'hC, 3'b010, 32'h0, 1'b0);
        add(1'b0, 32'h8, 3'b010, 32'h0, 1'b0);
        run_pipe("midrst_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of 32-bit storage words (power of two, 4..64).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving data-phase wait states per transfer (0..15; used only when AHB_SLV_WAIT_EN is defined).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port hresetn, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port hsel, input, 1 bit: slave select.
REQ-006 The block SHALL have port haddr, input, 32 bits: byte address.
REQ-007 The block SHALL have port htrans, input, 2 bits: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 The block SHALL have port hwrite, input, 1 bit: 1 means write, 0 means read.
REQ-009 The block SHALL have port hsize, input, 3 bits: transfer size.
REQ-010 The block SHALL have port hwdata, input, 32 bits: write data, valid in the data phase.
REQ-011 The block SHALL have port hready, input, 1 bit: bus-level ready.
REQ-012 The block SHALL have port hreadyout, output, 1 bit: slave ready.
REQ-013 The block SHALL have port hresp, output, 1 bit: 0 means OKAY, 1 means ERROR.
REQ-014 The block SHALL have port hrdata, output, 32 bits: read data returned to the master register bank.

Function
REQ-015 An address phase SHALL be accepted on a clk edge where hsel=1, hready=1 and htrans is NONSEQ or SEQ; haddr, hwrite and hsize are then registered.
REQ-016 A transfer SHALL be illegal if hsize!=3'b010, haddr[1:0]!=0, or the word index haddr[31:2]>=DEPTH.
REQ-017 The FSM SHALL have states IDLE, DATA, ERR1, ERR2, with reset state IDLE.
REQ-018 IDLE transitions: legal accept -> DATA; illegal accept -> ERR1; otherwise remain in IDLE with hreadyout=1 and hresp=0.
REQ-019 In DATA, the wait counter SHALL be loaded with WAIT_CYCLES on entry; hreadyout=0 while count>0, the counter decrements each cycle, and hreadyout=1 at count 0.
REQ-020 On the DATA cycle with hreadyout=1: a write stores hwdata at the registered index; a read drives hrdata=mem[index].
REQ-021 When a transfer completes in DATA and a new address phase is accepted on the same edge, the FSM SHALL go back-to-back to DATA (counter reloaded) or to ERR1, with no idle cycle.
REQ-022 In ERR1 the outputs SHALL be hreadyout=0, hresp=1; in ERR2, hreadyout=1, hresp=1; ERR2 then goes to IDLE, or to DATA/ERR1 if a new address phase is accepted.
REQ-023 Illegal transfers SHALL never modify storage and SHALL drive hrdata=0.
REQ-024 A read immediately following a write to the same address SHALL return the newly written data.
REQ-025 IDLE/BUSY transfers, or hsel=0, SHALL receive a zero-wait OKAY response and SHALL have no side effects.
REQ-026 hrdata SHALL hold 0 except on a read-completion cycle.

Reset
REQ-027 Assertion of hresetn SHALL immediately force: state=IDLE, hreadyout=1, hresp=0, hrdata=0, counter=0, and all storage words=0.
REQ-028 A reset asserted mid-transfer SHALL abort the transfer; a pending write is discarded.

Configuration
REQ-029 With macro AHB_SLV_WAIT_EN defined, wait states SHALL follow WAIT_CYCLES as in REQ-019.
REQ-030 Without AHB_SLV_WAIT_EN, no counter SHALL be built and every legal transfer SHALL complete in its first data-phase cycle.

Structure
REQ-031 Shared package ahb_pkg SHALL hold the htrans and hsize encodings, the OKAY/ERROR constants, and the FSM state enum.
REQ-032 Storage SHALL be a sub-module ahb_slv_regfile: DEPTH x 32, one synchronous write port, one combinational read port, async clear.

Verification
REQ-033 Write 0xDEADBEEF to 0x08, then read 0x08 (WAIT_CYCLES=2, macro on) -> hreadyout low 2 cycles per data phase; hrdata=0xDEADBEEF.
REQ-034 Back-to-back NONSEQ writes to 0x0,0x4,0x8 with data 1,2,3 (macro off) -> three consecutive hreadyout=1 cycles; subsequent reads return 1,2,3.
REQ-035 Read of 0x40 with DEPTH=16 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); hrdata=0; storage unchanged.
REQ-036 Write with hsize=3'b000 to 0x4 -> two-cycle ERROR response; a following read of 0x4 returns the prior value.
REQ-037 hresetn pulsed low during a write's wait state -> outputs go to reset values immediately; a later read of that address returns 0.
REQ-038 htrans=BUSY with hsel=1, and NONSEQ with hsel=0 -> hreadyout=1, hresp=0, no storage change.
